// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the two-port memory arbiter.
package mem_arb_pkg;
  typedef enum logic {PRIO_LS, PRIO_IF} arb_prio_t;
  typedef enum logic {PORT_IF, PORT_LS} arb_port_t;
  localparam int STARVE_W = 4;
endpackage

// File: rtl/arb_starve_cnt.sv
// Per-port denial counter: counts consecutive lost cycles, saturates at MAX.
// o_hit flags that the count will sit at MAX after this edge.
module arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_req,
  input  logic i_gnt,
  output logic o_hit
);

  localparam logic [STARVE_W-1:0] MAX_C = STARVE_W'(MAX);

  logic [STARVE_W-1:0] cnt_q;
  logic [STARVE_W-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (i_req && !i_gnt) begin
      cnt_d = (cnt_q == MAX_C) ? cnt_q : cnt_q + STARVE_W'(1);
    end
  end

  // Looking at the next value lets priority flip on the same edge the limit is reached.
  assign o_hit = (cnt_d == MAX_C);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IF and LS onto one single-port memory with a one-cycle registered
// response and a starvation guard that hands conflict priority to a waiting port.
//
//   state   | meaning
//   PRIO_LS | LS wins a simultaneous request
//   PRIO_IF | IF wins a simultaneous request
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [31:0]       o_if_rdata,
  input  logic              i_ls_req,
  input  logic [ADDR_W-1:0] i_ls_addr,
  input  logic [31:0]       i_ls_wdata,
  input  logic [3:0]        i_ls_bmask,
  input  logic              i_ls_wren,
  output logic              o_ls_gnt,
  output logic              o_ls_rvalid,
  output logic [31:0]       o_ls_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  output logic              o_mem_wren,
  input  logic [31:0]       i_mem_rdata
);

  arb_prio_t prio_q;
  arb_prio_t prio_d;
  arb_port_t win;
  logic      any_req;
  logic      if_hit;
  logic      ls_hit;

  always_comb begin
    win     = PORT_LS;
    any_req = 1'b0;
    if (!i_reset) begin
      if (i_if_req && i_ls_req) begin
        any_req = 1'b1;
        win     = (prio_q == PRIO_IF) ? PORT_IF : PORT_LS;
      end else if (i_if_req) begin
        any_req = 1'b1;
        win     = PORT_IF;
      end else if (i_ls_req) begin
        any_req = 1'b1;
        win     = PORT_LS;
      end
    end
  end

  assign o_if_gnt = any_req && (win == PORT_IF);
  assign o_ls_gnt = any_req && (win == PORT_LS);

  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_bmask = '0;
    o_mem_wren  = 1'b0;
    if (o_if_gnt) begin
      o_mem_addr = i_if_addr;
    end else if (o_ls_gnt) begin
      o_mem_addr  = i_ls_addr;
      o_mem_wdata = i_ls_wdata;
      o_mem_bmask = i_ls_bmask;
      o_mem_wren  = i_ls_wren;
    end
  end

  arb_starve_cnt #(.MAX(STARVE_MAX)) u_if_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_req   (i_if_req),
    .i_gnt   (o_if_gnt),
    .o_hit   (if_hit)
  );

  arb_starve_cnt #(.MAX(STARVE_MAX)) u_ls_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_req   (i_ls_req),
    .i_gnt   (o_ls_gnt),
    .o_hit   (ls_hit)
  );

  always_comb begin
    prio_d = prio_q;
    case (prio_q)
      PRIO_LS: if (if_hit) prio_d = PRIO_IF;
      PRIO_IF: if (ls_hit) prio_d = PRIO_LS;
      default: prio_d = PRIO_LS;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      prio_q <= PRIO_LS;
    end else begin
      prio_q <= prio_d;
    end
  end

  // rdata holds between responses; write acknowledges return zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_if_rvalid <= 1'b0;
      o_ls_rvalid <= 1'b0;
      o_if_rdata  <= '0;
      o_ls_rdata  <= '0;
    end else begin
      o_if_rvalid <= o_if_gnt;
      o_ls_rvalid <= o_ls_gnt;
      if (o_if_gnt) o_if_rdata <= i_mem_rdata;
      if (o_ls_gnt) o_ls_rdata <= i_ls_wren ? 32'h0 : i_mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a
// random phase, all outputs also compared every cycle against a behavioural model.
module tb_mem_arbiter;
  localparam int ADDR_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_gnt;
  logic              o_if_rvalid;
  logic [31:0]       o_if_rdata;
  logic              i_ls_req;
  logic [ADDR_W-1:0] i_ls_addr;
  logic [31:0]       i_ls_wdata;
  logic [3:0]        i_ls_bmask;
  logic              i_ls_wren;
  logic              o_ls_gnt;
  logic              o_ls_rvalid;
  logic [31:0]       o_ls_rdata;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic [3:0]        o_mem_bmask;
  logic              o_mem_wren;
  logic [31:0]       i_mem_rdata;

  mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_if_req    (i_if_req),
    .i_if_addr   (i_if_addr),
    .o_if_gnt    (o_if_gnt),
    .o_if_rvalid (o_if_rvalid),
    .o_if_rdata  (o_if_rdata),
    .i_ls_req    (i_ls_req),
    .i_ls_addr   (i_ls_addr),
    .i_ls_wdata  (i_ls_wdata),
    .i_ls_bmask  (i_ls_bmask),
    .i_ls_wren   (i_ls_wren),
    .o_ls_gnt    (o_ls_gnt),
    .o_ls_rvalid (o_ls_rvalid),
    .o_ls_rdata  (o_ls_rdata),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_bmask (o_mem_bmask),
    .o_mem_wren  (o_mem_wren),
    .i_mem_rdata (i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  // Memory the DUT drives, and an independent copy the model updates.
  logic [31:0] env_mem [16];
  logic [31:0] ref_mem [16];

  assign i_mem_rdata = env_mem[o_mem_addr[3:0]];

  always @(posedge i_clk) begin
    if (o_mem_wren) begin
      for (int b = 0; b < 4; b++)
        if (o_mem_bmask[b]) env_mem[o_mem_addr[3:0]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: which port wins conflicts, how long each has been waiting.
  bit          fav_ls;
  int          if_streak, ls_streak;
  logic        m_if_rv, m_ls_rv;
  logic [31:0] m_if_rd, m_ls_rd;
  logic        g_if_last, g_ls_last;

  initial begin
    logic        s_rst, eg_if, eg_ls, w_en;
    logic [31:0] e_addr, e_wdata, w_data;
    logic [3:0]  e_bmask, w_mask, w_addr;
    logic        e_wren, n_if_rv, n_ls_rv;
    logic [31:0] n_if_rd, n_ls_rd;
    int          if_streak_n, ls_streak_n;
    bit          fav_ls_n;
    fav_ls = 1'b1; if_streak = 0; ls_streak = 0;
    m_if_rv = 1'b0; m_ls_rv = 1'b0; m_if_rd = '0; m_ls_rd = '0;
    g_if_last = 1'b0; g_ls_last = 1'b0;
    @(posedge i_clk);
    forever begin
      @(negedge i_clk);
      s_rst = i_reset;
      eg_if = 1'b0; eg_ls = 1'b0;
      if (!s_rst) begin
        if (i_if_req && i_ls_req) begin
          if (fav_ls) eg_ls = 1'b1; else eg_if = 1'b1;
        end else begin
          eg_if = i_if_req;
          eg_ls = i_ls_req;
        end
      end
      e_addr = '0; e_wdata = '0; e_bmask = '0; e_wren = 1'b0;
      if (eg_if) e_addr = i_if_addr;
      if (eg_ls) begin
        e_addr = i_ls_addr; e_wdata = i_ls_wdata; e_bmask = i_ls_bmask; e_wren = i_ls_wren;
      end
      chk("if_gnt", o_if_gnt, eg_if);
      chk("ls_gnt", o_ls_gnt, eg_ls);
      chk("gnt_excl", o_if_gnt & o_ls_gnt, 0);
      chk("mem_addr", o_mem_addr, e_addr);
      chk("mem_wdata", o_mem_wdata, e_wdata);
      chk("mem_bmask", o_mem_bmask, e_bmask);
      chk("mem_wren", o_mem_wren, e_wren);
      chk("if_rvalid", o_if_rvalid, m_if_rv);
      chk("ls_rvalid", o_ls_rvalid, m_ls_rv);
      chk("if_rdata", o_if_rdata, m_if_rd);
      chk("ls_rdata", o_ls_rdata, m_ls_rd);
      g_if_last = eg_if; g_ls_last = eg_ls;

      n_if_rv = eg_if; n_ls_rv = eg_ls;
      n_if_rd = eg_if ? ref_mem[i_if_addr[3:0]] : m_if_rd;
      n_ls_rd = eg_ls ? (i_ls_wren ? 32'h0 : ref_mem[i_ls_addr[3:0]]) : m_ls_rd;
      w_en = eg_ls && i_ls_wren;
      w_addr = i_ls_addr[3:0]; w_data = i_ls_wdata; w_mask = i_ls_bmask;
      // A port that has waited STARVE_MAX cycles in a row owns the next conflict.
      if_streak_n = (i_if_req && !eg_if) ? if_streak + 1 : 0;
      ls_streak_n = (i_ls_req && !eg_ls) ? ls_streak + 1 : 0;
      fav_ls_n = fav_ls;
      if (fav_ls && if_streak_n == STARVE_MAX) fav_ls_n = 1'b0;
      if (!fav_ls && ls_streak_n == STARVE_MAX) fav_ls_n = 1'b1;

      @(posedge i_clk);
      if (s_rst) begin
        fav_ls = 1'b1; if_streak = 0; ls_streak = 0;
        m_if_rv = 1'b0; m_ls_rv = 1'b0; m_if_rd = '0; m_ls_rd = '0;
      end else begin
        fav_ls = fav_ls_n; if_streak = if_streak_n; ls_streak = ls_streak_n;
        m_if_rv = n_if_rv; m_ls_rv = n_ls_rv; m_if_rd = n_if_rd; m_ls_rd = n_ls_rd;
        if (w_en)
          for (int b = 0; b < 4; b++)
            if (w_mask[b]) ref_mem[w_addr][8*b +: 8] = w_data[8*b +: 8];
      end
    end
  end

  initial begin
    logic [11:0] pat3;
    logic [4:0]  pat5;
    for (int i = 0; i < 16; i++) begin
      env_mem[i] = 32'hC0DE0000 | 32'(i);
      ref_mem[i] = 32'hC0DE0000 | 32'(i);
    end
    env_mem[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
    env_mem[8] = 32'hAABBCCDD; ref_mem[8] = 32'hAABBCCDD;
    i_reset = 1'b1;
    i_if_req = 1'b0; i_if_addr = '0;
    i_ls_req = 1'b0; i_ls_addr = '0; i_ls_wdata = '0; i_ls_bmask = '0; i_ls_wren = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 i_reset = 1'b0;
    @(negedge i_clk);
    chk("rst_if_rvalid", o_if_rvalid, 0);
    chk("rst_ls_rdata", o_ls_rdata, 0);

    // IF alone reads address 5
    @(posedge i_clk); #1 i_if_req = 1'b1; i_if_addr = 32'd5;
    @(negedge i_clk);
    chk("t1_if_gnt", o_if_gnt, 1);
    chk("t1_mem_addr", o_mem_addr, 32'd5);
    @(posedge i_clk); #1 i_if_req = 1'b0;
    @(negedge i_clk);
    chk("t1_if_rvalid", o_if_rvalid, 1);
    chk("t1_if_rdata", o_if_rdata, 32'hDEADBEEF);
    chk("t1_ls_rvalid", o_ls_rvalid, 0);

    // LS partial write then read-back of address 8
    @(posedge i_clk); #1
    i_ls_req = 1'b1; i_ls_addr = 32'd8; i_ls_wdata = 32'h11223344; i_ls_bmask = 4'b0011; i_ls_wren = 1'b1;
    @(negedge i_clk);
    chk("t2_wr_gnt", o_ls_gnt, 1);
    chk("t2_wr_wren", o_mem_wren, 1);
    @(posedge i_clk); #1 i_ls_wren = 1'b0; i_ls_bmask = 4'b0000; i_ls_wdata = '0;
    @(negedge i_clk);
    chk("t2_rd_wren", o_mem_wren, 0);
    chk("t2_ack_rvalid", o_ls_rvalid, 1);
    chk("t2_ack_rdata", o_ls_rdata, 0);
    @(posedge i_clk); #1 i_ls_req = 1'b0;
    @(negedge i_clk);
    chk("t2_rd_rvalid", o_ls_rvalid, 1);
    chk("t2_rd_rdata", o_ls_rdata, 32'hAABB3344);
    chk("t2_model_mem8", ref_mem[8], 32'hAABB3344);

    // Back-to-back IF reads of 0..3
    for (int k = 0; k < 4; k++) begin
      @(posedge i_clk); #1 i_if_req = 1'b1; i_if_addr = 32'(k);
      @(negedge i_clk);
      chk("t4_if_gnt", o_if_gnt, 1);
      if (k > 0) begin
        chk("t4_if_rvalid", o_if_rvalid, 1);
        chk("t4_if_rdata", o_if_rdata, 32'hC0DE0000 | 32'(k - 1));
      end
    end
    @(posedge i_clk); #1 i_if_req = 1'b0;
    @(negedge i_clk);
    chk("t4_if_rvalid_last", o_if_rvalid, 1);
    chk("t4_if_rdata_last", o_if_rdata, 32'hC0DE0003);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("t4_if_rvalid_end", o_if_rvalid, 0);

    // Both request continuously out of reset: LS x4, IF x4, LS x4
    @(posedge i_clk); #1
    i_reset = 1'b1; i_if_req = 1'b1; i_if_addr = 32'd1; i_ls_req = 1'b1; i_ls_addr = 32'd2; i_ls_wren = 1'b0;
    @(negedge i_clk);
    chk("t3_rst_if_gnt", o_if_gnt, 0);
    chk("t3_rst_ls_gnt", o_ls_gnt, 0);
    @(posedge i_clk); #1 i_reset = 1'b0;
    pat3 = 12'hF0F;
    for (int k = 0; k < 12; k++) begin
      @(negedge i_clk);
      chk("t3_ls_gnt", o_ls_gnt, pat3[k]);
      chk("t3_if_gnt", o_if_gnt, !pat3[k]);
      @(posedge i_clk); #1;
    end

    // Priority now favours IF; reset right after an LS read grant must restore LS priority
    i_if_req = 1'b0; i_ls_addr = 32'd9;
    @(negedge i_clk);
    chk("t5_ls_gnt", o_ls_gnt, 1);
    @(posedge i_clk); #1 i_reset = 1'b1; i_if_req = 1'b1; i_ls_addr = 32'd2; i_ls_wren = 1'b1; i_ls_bmask = 4'hF;
    @(negedge i_clk);
    chk("t5_rst_wren", o_mem_wren, 0);
    chk("t5_rst_ls_gnt", o_ls_gnt, 0);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("t5_ls_rvalid", o_ls_rvalid, 0);
    chk("t5_rst_wren2", o_mem_wren, 0);
    @(posedge i_clk); #1 i_reset = 1'b0; i_ls_wren = 1'b0; i_ls_bmask = 4'h0;
    pat5 = 5'b01111;
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      chk("t5_ls_gnt_after", o_ls_gnt, pat5[k]);
      @(posedge i_clk); #1;
    end
    i_if_req = 1'b0; i_ls_req = 1'b0;

    // Random traffic with requesters that hold until granted
    for (int n = 0; n < 10000; n++) begin
      @(posedge i_clk); #1;
      i_reset = ($urandom_range(0, 499) == 0);
      if (!i_if_req || g_if_last) begin
        i_if_req  = ($urandom_range(0, 2) != 0);
        i_if_addr = 32'($urandom_range(0, 15));
      end
      if (!i_ls_req || g_ls_last) begin
        i_ls_req   = ($urandom_range(0, 2) != 0);
        i_ls_addr  = 32'($urandom_range(0, 15));
        i_ls_wdata = $urandom;
        i_ls_bmask = 4'($urandom_range(0, 15));
        i_ls_wren  = $urandom_range(0, 1) == 1;
      end
    end
    @(posedge i_clk); #1 i_reset = 1'b0; i_if_req = 1'b0; i_ls_req = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
